// File: rtl/gcore_pkg.sv
// +--------------------------------------------------------------------------+
// | gcore_pkg : shared constants for the GCore 8-bit control path            |
// | Optional build macro: GCORE_ILLEGAL_TRAP_EN (adds the TRAP state)        |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package gcore_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_BZ  = 3'b111;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_J    = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_IMM = 2'b01;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
`ifdef GCORE_ILLEGAL_TRAP_EN
    localparam logic [2:0] S_TRAP   = 3'd6;
`endif

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_b;
        logic       is_rtype;
        logic       is_mem;
        logic       is_branch;
        logic       is_illegal;
    } dec_t;

endpackage

`default_nettype wire

// File: rtl/gcore_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | gcore_ctrl_if : controller <-> memory/datapath signal bundle             |
// | Optional build macro: GCORE_ILLEGAL_TRAP_EN (adds illegal)               |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface gcore_ctrl_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic [2:0]  alu_op;
    logic        alu_src_b;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        reg_write;
    logic        mem_to_reg;
    logic        halted;
    logic        fault;
`ifdef GCORE_ILLEGAL_TRAP_EN
    logic        illegal;

    modport master (
        input  instr, mem_ready, zero,
        output alu_op, alu_src_b, ir_write, pc_write, pc_src, mem_read,
               mem_write, iord, reg_write, mem_to_reg, halted, fault, illegal
    );
    modport slave (
        output instr, mem_ready, zero,
        input  alu_op, alu_src_b, ir_write, pc_write, pc_src, mem_read,
               mem_write, iord, reg_write, mem_to_reg, halted, fault, illegal
    );
`else
    modport master (
        input  instr, mem_ready, zero,
        output alu_op, alu_src_b, ir_write, pc_write, pc_src, mem_read,
               mem_write, iord, reg_write, mem_to_reg, halted, fault
    );
    modport slave (
        output instr, mem_ready, zero,
        input  alu_op, alu_src_b, ir_write, pc_write, pc_src, mem_read,
               mem_write, iord, reg_write, mem_to_reg, halted, fault
    );
`endif
endinterface

`default_nettype wire

// File: rtl/gcore_ctrl_decode.sv
// +--------------------------------------------------------------------------+
// | gcore_ctrl_decode : combinational opcode classifier and ALU op select    |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module gcore_ctrl_decode
    import gcore_pkg::*;
(
    input  logic [3:0] opcode_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OP_ADD:  begin dec_o.alu_op = ALU_ADD; dec_o.is_rtype = 1'b1; end
            OP_SUB:  begin dec_o.alu_op = ALU_SUB; dec_o.is_rtype = 1'b1; end
            OP_AND:  begin dec_o.alu_op = ALU_AND; dec_o.is_rtype = 1'b1; end
            OP_OR:   begin dec_o.alu_op = ALU_OR;  dec_o.is_rtype = 1'b1; end
            OP_XOR:  begin dec_o.alu_op = ALU_XOR; dec_o.is_rtype = 1'b1; end
            OP_SLT:  begin dec_o.alu_op = ALU_SLT; dec_o.is_rtype = 1'b1; end
            // Address and immediate forms all add imm8 on the B input
            OP_ADDI, OP_LD, OP_ST: begin
                dec_o.alu_op    = ALU_ADD;
                dec_o.alu_src_b = 1'b1;
                dec_o.is_mem    = (opcode_i != OP_ADDI);
            end
            OP_BZ:   begin dec_o.alu_op = ALU_BZ; dec_o.is_branch = 1'b1; end
            OP_J, OP_HALT: ;
            default: dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gcore_ctrl.sv
// +--------------------------------------------------------------------------+
// | gcore_ctrl : multicycle control FSM with optional memory timeout         |
// | Optional build macro: GCORE_ILLEGAL_TRAP_EN (traps undefined opcodes)    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module gcore_ctrl
    import gcore_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    gcore_ctrl_if.master bus
);

    logic [2:0] state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic       fault_q, fault_d;
    logic       w_ready, w_wait, w_timeout;
    dec_t       w_dec;

    // Handshake strobes stay low while reset is held, even if memory is ready
    assign w_ready  = bus.mem_ready & rst_n;
    assign w_wait   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
    assign opcode_d = ((state_q == S_FETCH) && w_ready) ? bus.instr[15:12] : opcode_q;
    assign fault_d  = fault_q | w_timeout;

    gcore_ctrl_decode u_decode (
        .opcode_i (opcode_q),
        .dec_o    (w_dec)
    );

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                    cnt_q <= '0;
                else if (w_wait && !w_timeout) cnt_q <= cnt_q + 1'b1;
                else                           cnt_q <= '0;
            end

            assign w_timeout = w_wait && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.fault = fault_q;

    always_comb begin
        state_d        = state_q;
        bus.alu_op     = ALU_ADD;
        bus.alu_src_b  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_SRC_INC;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.halted     = 1'b0;
`ifdef GCORE_ILLEGAL_TRAP_EN
        bus.illegal    = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (w_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_SRC_INC;
                    state_d      = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (opcode_q == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode_q == OP_J) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_SRC_IMM;
                    state_d      = S_FETCH;
                end else if (w_dec.is_illegal) begin
`ifdef GCORE_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.alu_op    = w_dec.alu_op;
                bus.alu_src_b = w_dec.alu_src_b;
                // BZ evaluates rs==0 to 1, so a zero flag of 0 means taken
                if (w_dec.is_branch) begin
                    bus.pc_write = !bus.zero;
                    bus.pc_src   = PC_SRC_IMM;
                    state_d      = S_FETCH;
                end else if (w_dec.is_mem) begin
                    state_d = S_MEM;
                end else if (w_dec.is_rtype || (opcode_q == OP_ADDI)) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                bus.iord      = 1'b1;
                bus.alu_src_b = 1'b1;
                bus.mem_read  = (opcode_q == OP_LD);
                bus.mem_write = (opcode_q == OP_ST);
                if (bus.mem_ready)  state_d = (opcode_q == OP_LD) ? S_WB : S_FETCH;
                else if (w_timeout) state_d = S_HALT;
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (opcode_q == OP_LD);
                bus.alu_op     = w_dec.alu_op;
                bus.alu_src_b  = w_dec.alu_src_b;
                state_d        = S_FETCH;
            end
            S_HALT: bus.halted = 1'b1;
`ifdef GCORE_ILLEGAL_TRAP_EN
            S_TRAP: begin
                bus.halted  = 1'b1;
                bus.illegal = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

endmodule

`default_nettype wire
